// File: rtl/ddr_out_serializer_pkg.sv
// Shared types and elaboration helpers for the DDR output serializer.
package ddr_out_ser_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_LEAD     = 2'd1,
        S_SHIFT    = 2'd2,
        S_GUARD_ST = 2'd3
    } ddr_ser_state_t;

    // Floor for the sequencing counter width.
    localparam int DDR_SER_CNT_W = 4;

    function automatic int ddr_ser_cnt_w(input int width, input int lead, input int guard);
        int m;
        m = width / 2;
        if (lead > m) begin
            m = lead;
        end else begin
            m = m;
        end
        if (guard > m) begin
            m = guard;
        end else begin
            m = m;
        end
        return ($clog2(m + 1) > DDR_SER_CNT_W) ? $clog2(m + 1) : DDR_SER_CNT_W;
    endfunction

    function automatic bit ddr_ser_params_ok(input int width, input int lead, input int guard);
        return (width >= 2) && ((width % 2) == 0) && (lead >= 0) && (lead <= 15) &&
               (guard >= 1) && (guard <= 15);
    endfunction

endpackage

// File: rtl/ddr_out_serializer_if.sv
// Word handshake between the upstream producer and the DDR output serializer.
interface ddr_out_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] s_data;
    logic             s_valid;
    logic             s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/ddr_out_serializer_shreg.sv
// WIDTH-bit load / shift-by-2 register; exposes the low pair of its next value.
module ddr_ser_shreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic [1:0]       sr_lo_d_o
);
    logic [WIDTH-1:0] sr_d;
    logic [WIDTH-1:0] sr_q;

    // Load wins over shift so a streaming reload never drops the new word.
    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = din;
        end else if (shift) begin
            sr_d = sr_q >> 2;
        end else begin
            sr_d = sr_q;
        end
    end

    // Shift register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign sr_lo_d_o = sr_d[1:0];
endmodule

// File: rtl/ddr_out_serializer.sv
// Parallel-to-DDR serializer for an iCE40UP registered DDR IO cell with OE sequencing.
// Define DDR_OUT_SER_GUARD_EN to hold OE for GUARD cycles after the last bit pair.
module ddr_out_serializer
    import ddr_out_ser_pkg::*;
#(
    parameter int   WIDTH    = 8,
    parameter int   OE_LEAD  = 1,
    parameter int   GUARD    = 2,
    parameter logic IDLE_BIT = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ddr_out_serializer_if.slave  s,
    output logic                 d_out_0,
    output logic                 d_out_1,
    output logic                 output_enable,
    output logic                 busy
);
    localparam int             CNT_W      = ddr_ser_cnt_w(WIDTH, OE_LEAD, GUARD);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] SHIFT_LOAD = CNT_W'(WIDTH / 2 - 1);
    localparam logic [CNT_W-1:0] LEAD_LOAD  = CNT_W'((OE_LEAD > 0) ? (OE_LEAD - 1) : 0);
`ifdef DDR_OUT_SER_GUARD_EN
    localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD - 1);
`endif

    if (!ddr_ser_params_ok(WIDTH, OE_LEAD, GUARD)) begin : g_param_check
        $error("ddr_out_serializer: WIDTH must be even >=2, OE_LEAD 0..15, GUARD 1..15");
    end

    ddr_ser_state_t   state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             live_d, live_q;
    logic             d0_d, d0_q, d1_d, d1_q, oe_d, oe_q, busy_d, busy_q;
    logic             ready_s, accept_s, load_s, shift_s;
    logic [1:0]       sr_lo_d_s;

    ddr_ser_shreg #(.WIDTH(WIDTH)) u_shreg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_s),
        .shift     (shift_s),
        .din       (s.s_data),
        .sr_lo_d_o (sr_lo_d_s)
    );

    // live_q keeps s_ready low until the first edge after reset release.
    assign ready_s  = live_q & ((state_q == S_IDLE) |
                                ((state_q == S_SHIFT) & (cnt_q == '0)));
    assign accept_s = ready_s & s.s_valid;
    assign s.s_ready = ready_s;

    // Next-state and counter; cnt_q counts down to zero in each timed state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load_s  = 1'b0;
        shift_s = 1'b0;
        live_d  = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    load_s = 1'b1;
                    if (OE_LEAD == 0) begin
                        state_d = S_SHIFT;
                        cnt_d   = SHIFT_LOAD;
                    end else begin
                        state_d = S_LEAD;
                        cnt_d   = LEAD_LOAD;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LEAD: begin
                if (cnt_q == '0) begin
                    state_d = S_SHIFT;
                    cnt_d   = SHIFT_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_SHIFT: begin
                if (cnt_q != '0) begin
                    shift_s = 1'b1;
                    cnt_d   = cnt_q - CNT_ONE;
                end else if (accept_s) begin
                    load_s = 1'b1;
                    cnt_d  = SHIFT_LOAD;
                end else begin
`ifdef DDR_OUT_SER_GUARD_EN
                    state_d = S_GUARD_ST;
                    cnt_d   = GUARD_LOAD;
`else
                    state_d = S_IDLE;
                    cnt_d   = '0;
`endif
                end
            end
`ifdef DDR_OUT_SER_GUARD_EN
            S_GUARD_ST: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Pin flops follow the upcoming state so each pair is valid for the whole cycle.
    always_comb begin
        oe_d   = (state_d != S_IDLE);
        busy_d = (state_d != S_IDLE);
        if (state_d == S_SHIFT) begin
            d0_d = sr_lo_d_s[0];
            d1_d = sr_lo_d_s[1];
        end else begin
            d0_d = IDLE_BIT;
            d1_d = IDLE_BIT;
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            live_q  <= 1'b0;
            d0_q    <= IDLE_BIT;
            d1_q    <= IDLE_BIT;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            live_q  <= live_d;
            d0_q    <= d0_d;
            d1_q    <= d1_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
        end
    end

    assign d_out_0       = d0_q;
    assign d_out_1       = d1_q;
    assign output_enable = oe_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_ddr_out_serializer.sv
// Scoreboard bench: stimulus queues per-cycle expected pin states, monitors pop and compare.
module tb_ddr_out_serializer;
    typedef struct packed {
        logic oe;
        logic d0;
        logic d1;
        logic busy;
        logic rdy;
    } exp_t;

    typedef struct {
        exp_t  e;
        string nm;
    } item_t;

    localparam exp_t E_IDLE  = '{oe: 1'b0, d0: 1'b1, d1: 1'b1, busy: 1'b0, rdy: 1'b1};
    localparam exp_t E_HOLD  = '{oe: 1'b1, d0: 1'b1, d1: 1'b1, busy: 1'b1, rdy: 1'b0};
    localparam exp_t E_RST   = '{oe: 1'b0, d0: 1'b1, d1: 1'b1, busy: 1'b0, rdy: 1'b0};

    logic  clk;
    logic  rst_n;
    logic  a_d0, a_d1, a_oe, a_busy;
    logic  b_d0, b_d1, b_oe, b_busy;
    int    n_cmp;
    int    n_err;
    string tname;
    item_t qa[$];
    item_t qb[$];

    ddr_out_serializer_if #(.WIDTH(8)) ia ();
    ddr_out_serializer_if #(.WIDTH(8)) ib ();

    ddr_out_serializer #(.WIDTH(8), .OE_LEAD(1), .GUARD(2), .IDLE_BIT(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .s(ia),
        .d_out_0(a_d0), .d_out_1(a_d1), .output_enable(a_oe), .busy(a_busy)
    );

    ddr_out_serializer #(.WIDTH(8), .OE_LEAD(0), .GUARD(2), .IDLE_BIT(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .s(ib),
        .d_out_0(b_d0), .d_out_1(b_d1), .output_enable(b_oe), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t pr(input logic d0, input logic d1, input logic rdy);
        return '{oe: 1'b1, d0: d0, d1: d1, busy: 1'b1, rdy: rdy};
    endfunction

    task automatic compare(input string nm, input exp_t e, input exp_t a);
        n_cmp++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: oe,d0,d1,busy,rdy got %b required %b", nm, a, e);
        end
    endtask

    // One clock of stimulus on DUT 'which' plus the pin state expected after that edge.
    task automatic step(input int which, input logic v, input logic [7:0] d, input exp_t e);
        item_t it;
        it.e  = e;
        it.nm = tname;
        if (which == 0) begin
            ia.s_valid = v;
            ia.s_data  = d;
            qa.push_back(it);
        end else begin
            ib.s_valid = v;
            ib.s_data  = d;
            qb.push_back(it);
        end
        @(posedge clk);
        #2;
    endtask

    // Leave the final SHIFT cycle; in the guard build toggle the inputs during GUARD_ST.
    task automatic drain(input int which, input logic [7:0] jd);
`ifdef DDR_OUT_SER_GUARD_EN
        step(which, 1'b0, 8'h00, E_HOLD);
        step(which, 1'b1, jd, E_HOLD);
        step(which, 1'b1, ~jd, E_IDLE);
`else
        step(which, 1'b0, 8'h00, E_IDLE);
`endif
    endtask

    // 8'hA5 with junk on the inputs while not ready.
    task automatic send_a5();
        step(0, 1'b1, 8'hA5, E_HOLD);
        step(0, 1'b1, 8'h00, pr(1'b1, 1'b0, 1'b0));
        step(0, 1'b0, 8'h5A, pr(1'b1, 1'b0, 1'b0));
        step(0, 1'b1, 8'hFF, pr(1'b0, 1'b1, 1'b0));
        step(0, 1'b1, 8'h33, pr(1'b0, 1'b1, 1'b1));
        drain(0, 8'h77);
    endtask

    always @(posedge clk) begin : mon_a
        item_t it;
        #1;
        if (qa.size() != 0) begin
            it = qa.pop_front();
            compare({it.nm, "_a"}, it.e, {a_oe, a_d0, a_d1, a_busy, ia.s_ready});
        end
    end

    always @(posedge clk) begin : mon_b
        item_t it;
        #1;
        if (qb.size() != 0) begin
            it = qb.pop_front();
            compare({it.nm, "_b"}, it.e, {b_oe, b_d0, b_d1, b_busy, ib.s_ready});
        end
    end

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        tname      = "reset";
        rst_n      = 1'b0;
        ia.s_valid = 1'b0;
        ia.s_data  = 8'h00;
        ib.s_valid = 1'b0;
        ib.s_data  = 8'h00;
        #23;
        compare("reset_a", E_RST, {a_oe, a_d0, a_d1, a_busy, ia.s_ready});
        compare("reset_b", E_RST, {b_oe, b_d0, b_d1, b_busy, ib.s_ready});
        @(negedge clk);
        rst_n = 1'b1;

        tname = "idle";
        for (int i = 0; i < 10; i++) begin
            step(0, 1'b0, 8'h00, E_IDLE);
        end

        tname = "single_a5";
        send_a5();

        // 0F, F0, 3C streamed; F0 and 3C are accepted in the final SHIFT cycles.
        tname = "stream";
        step(0, 1'b1, 8'h0F, E_HOLD);
        step(0, 1'b1, 8'hF0, pr(1'b1, 1'b1, 1'b0));
        step(0, 1'b1, 8'hF0, pr(1'b1, 1'b1, 1'b0));
        step(0, 1'b1, 8'hF0, pr(1'b0, 1'b0, 1'b0));
        step(0, 1'b1, 8'hF0, pr(1'b0, 1'b0, 1'b1));
        step(0, 1'b1, 8'hF0, pr(1'b0, 1'b0, 1'b0));
        step(0, 1'b1, 8'h3C, pr(1'b0, 1'b0, 1'b0));
        step(0, 1'b1, 8'h3C, pr(1'b1, 1'b1, 1'b0));
        step(0, 1'b1, 8'h3C, pr(1'b1, 1'b1, 1'b1));
        step(0, 1'b1, 8'h3C, pr(1'b0, 1'b0, 1'b0));
        step(0, 1'b0, 8'h00, pr(1'b1, 1'b1, 1'b0));
        step(0, 1'b0, 8'h00, pr(1'b1, 1'b1, 1'b0));
        step(0, 1'b0, 8'h00, pr(1'b0, 1'b0, 1'b1));
        drain(0, 8'hC3);

        // Reset asserted during the second SHIFT cycle of 8'h55.
        tname = "rst_mid";
        step(0, 1'b1, 8'h55, E_HOLD);
        step(0, 1'b0, 8'h00, pr(1'b1, 1'b0, 1'b0));
        step(0, 1'b0, 8'h00, pr(1'b1, 1'b0, 1'b0));
        rst_n = 1'b0;
        #1;
        compare("rst_mid_async", E_RST, {a_oe, a_d0, a_d1, a_busy, ia.s_ready});
        @(negedge clk);
        rst_n = 1'b1;
        tname = "after_rst";
        step(0, 1'b0, 8'h00, E_IDLE);
        send_a5();

        // Zero lead-in: OE and the first pair appear together.
        tname = "lead0";
        step(1, 1'b0, 8'h00, E_IDLE);
        step(1, 1'b1, 8'hFF, pr(1'b1, 1'b1, 1'b0));
        step(1, 1'b1, 8'h00, pr(1'b1, 1'b1, 1'b0));
        step(1, 1'b1, 8'h00, pr(1'b1, 1'b1, 1'b0));
        step(1, 1'b1, 8'h00, pr(1'b1, 1'b1, 1'b1));
        drain(1, 8'h18);

        repeat (2) @(posedge clk);
        #2;
        n_cmp++;
        if ((qa.size() + qb.size()) != 0) begin
            n_err++;
            $display("FAIL drain_queues: %0d expectations left, required 0", qa.size() + qb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
